// File: rtl/ctrl_frame_capturer_if.sv
// picosoc iomem bus bundle for ctrl_frame_capturer.
// The CPU side drives the request; the capturer answers with ready/rdata.
interface ctrl_frame_capturer_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/ctrl_frame_capturer.sv
// Captures one RX frame from the CPU-port FIFO into a 16x32 RAM readable over iomem.
// Optional destination-address filter is built in when CTRL_RX_FILTER_EN is defined.
module ctrl_frame_capturer (
  input  logic       clk,
  input  logic       srst,
  input  logic [7:0] i_fifo_dout,
  input  logic       i_fifo_del,
  input  logic       i_fifo_empty,
  output logic       o_fifo_rden,
  ctrl_frame_capturer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RX   = 2'd1,
    S_DROP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [10:0] CNT_MAX = 11'd2047;

  state_e      state_q, state_d;
  logic        rx_en_q, rx_en_d;
  logic        overflow_q, overflow_d;
  logic [10:0] frame_len_q, frame_len_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic [10:0] cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ram_q [16];

  logic        pop_s, ram_we_s, filter_drop_s;
  logic [10:0] cnt_inc_s;
  logic        bus_acc_s, cfg_sel_s, ram_sel_s, cfg_wr_s, release_s;
  logic        frame_valid_s, busy_s;
  logic [31:0] cfg_word_s;
  logic        unused_s;

`ifdef CTRL_RX_FILTER_EN
  // Broadcast or 802.1D reserved group address 01:80:C2:00:00:0X.
  function automatic logic dest_ok(input logic [31:0] w0, input logic [7:0] b4,
                                   input logic [7:0] b5);
    logic bcast;
    logic rsvd;
    bcast = (w0 == 32'hFFFF_FFFF) && (b4 == 8'hFF) && (b5 == 8'hFF);
    rsvd  = (w0 == 32'h00C2_8001) && (b4 == 8'h00) && (b5[7:4] == 4'h0);
    return bcast | rsvd;
  endfunction

  assign filter_drop_s = (cnt_q == 11'd5) & ~dest_ok(ram_q[0], ram_q[1][7:0], i_fifo_dout);
`else
  assign filter_drop_s = 1'b0;
`endif

  assign unused_s = ^{bus.iomem_addr[23:6], bus.iomem_addr[1:0], bus.iomem_wdata[30:29],
                      bus.iomem_wdata[27:0], bus.iomem_wstrb[2:0]};

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;

  // Bus decode, config write strobes and registered read data.
  always_comb begin
    frame_valid_s = (state_q == S_DONE);
    busy_s        = (state_q == S_RX) || (state_q == S_DROP);
    cfg_word_s    = {rx_en_q, frame_valid_s, busy_s, 1'b0, overflow_q, 3'b000,
                     drop_cnt_q, 5'b00000, frame_len_q};
    bus_acc_s     = bus.iomem_valid & ~ready_q;
    cfg_sel_s     = (bus.iomem_addr[31:24] == 8'h16);
    ram_sel_s     = (bus.iomem_addr[31:24] == 8'h06);
    cfg_wr_s      = bus_acc_s & cfg_sel_s & bus.iomem_wstrb[3];
    release_s     = cfg_wr_s & bus.iomem_wdata[28];
    ready_d       = bus_acc_s;
    rdata_d       = rdata_q;
    if (bus_acc_s) begin
      if (cfg_sel_s) begin
        rdata_d = cfg_word_s;
      end else if (ram_sel_s) begin
        rdata_d = ram_q[bus.iomem_addr[5:2]];
      end else begin
        rdata_d = 32'd0;
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Capture FSM next state, FIFO pop and status updates.
  always_comb begin
    state_d     = state_q;
    overflow_d  = overflow_q;
    frame_len_d = frame_len_q;
    drop_cnt_d  = drop_cnt_q;
    cnt_d       = cnt_q;
    pop_s       = 1'b0;
    ram_we_s    = 1'b0;
    rx_en_d     = cfg_wr_s ? bus.iomem_wdata[31] : rx_en_q;
    cnt_inc_s   = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + 11'd1);
    case (state_q)
      S_IDLE: begin
        if (rx_en_q & ~i_fifo_empty) begin
          state_d    = S_RX;
          cnt_d      = 11'd0;
          overflow_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RX: begin
        pop_s = ~i_fifo_empty;
        if (pop_s) begin
          ram_we_s = (cnt_q < 11'd64);
          cnt_d    = cnt_inc_s;
          // End of frame wins over the filter so 6-byte frames are kept.
          if (i_fifo_del) begin
            frame_len_d = cnt_inc_s;
            overflow_d  = (cnt_q >= 11'd64);
            state_d     = S_DONE;
          end else if (filter_drop_s) begin
            state_d    = S_DROP;
            drop_cnt_d = (drop_cnt_q == 8'hFF) ? 8'hFF : (drop_cnt_q + 8'd1);
          end else begin
            state_d = S_RX;
          end
        end else begin
          state_d = S_RX;
        end
      end
      S_DROP: begin
        pop_s = ~i_fifo_empty;
        if (pop_s & i_fifo_del) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DROP;
        end
      end
      S_DONE: begin
        if (release_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    o_fifo_rden = pop_s & ~srst;
  end

  // State, status and bus response registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= S_IDLE;
      rx_en_q     <= 1'b0;
      overflow_q  <= 1'b0;
      frame_len_q <= 11'd0;
      drop_cnt_q  <= 8'd0;
      cnt_q       <= 11'd0;
      ready_q     <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      rx_en_q     <= rx_en_d;
      overflow_q  <= overflow_d;
      frame_len_q <= frame_len_d;
      drop_cnt_q  <= drop_cnt_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
    end
  end

  // Capture RAM, written one byte lane per pop.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < 16; i++) begin
        ram_q[i] <= 32'd0;
      end
    end else if (ram_we_s) begin
      ram_q[cnt_q[5:2]][{cnt_q[1:0], 3'b000} +: 8] <= i_fifo_dout;
    end
  end

endmodule

// File: doc/ctrl_frame_capturer.md
CTRL_FRAME_CAPTURER -- requirements
Module: ctrl_frame_capturer

Interface
REQ-001 SHALL have: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have: srst  in  1  reset; synchronous and active-high.
REQ-003 SHALL have: i_fifo_dout  in  8  CPU-port RX FIFO byte; show-ahead, valid whenever i_fifo_empty=0.
REQ-004 SHALL have: i_fifo_del  in  1  last byte of frame, aligned with i_fifo_dout.
REQ-005 SHALL have: i_fifo_empty  in  1  RX FIFO empty.
REQ-006 SHALL have: o_fifo_rden  out  1  pop one byte this cycle.
REQ-007 SHALL have picosoc port: iomem_valid in 1, iomem_ready out 1, iomem_wstrb in 4, iomem_addr in 32, iomem_wdata in 32, iomem_rdata out 32.

Function
REQ-008 SHALL hold a 16x32 capture RAM (64 bytes); frame byte n goes to word n[5:2], lane n[1:0] (byte 0 in bits [7:0]).
REQ-009 SHALL decode config register at iomem_addr[31:24]=8'h16 and the RAM window at 8'h06, word index iomem_addr[5:2]; other addresses are ignored.
REQ-010 SHALL assert iomem_ready for exactly one cycle, the cycle after iomem_valid is seen with ready low, with iomem_rdata valid in that same cycle.
REQ-011 SHALL treat the RAM window as read-only; writes complete with ready and change nothing.
REQ-012 SHALL map config: [31] rx_en RW; [30] frame_valid R; [29] busy R (state is neither S_IDLE nor S_DONE); [28] release W1, reads 0; [27] overflow R; [23:16] drop_cnt R; [10:0] frame_len R; all other bits read 0.
REQ-013 SHALL write config only when iomem_wstrb[3]=1.
REQ-014 SHALL implement states S_IDLE, S_RX, S_DROP, S_DONE.
REQ-015 S_IDLE: if rx_en=1 and i_fifo_empty=0, go to S_RX, clear byte counter, clear overflow; otherwise do not pop.
REQ-016 S_RX: o_fifo_rden = ~i_fifo_empty (combinational); each pop stores the byte if counter<64, and the counter increments and saturates at 2047.
REQ-017 S_RX: on a pop with i_fifo_del=1, set frame_len to counter+1 (saturating at 2047), set overflow if counter>=64, and go to S_DONE.
REQ-018 S_DONE: frame_valid=1 and no pops; a release write returns the block to S_IDLE and clears frame_valid the next cycle.
REQ-019 SHALL ignore release while not in S_DONE.
REQ-020 SHALL finish the current frame normally if rx_en is cleared mid-frame; rx_en only gates the S_IDLE exit.
REQ-021 S_DROP: pop each available byte and discard it; on a pop with del=1, return to S_IDLE without setting frame_valid.
REQ-022 SHALL return current RAM contents on CPU reads during capture; no interlock.
REQ-023 Latency: first pop occurs 1 cycle after S_IDLE sees data; a frame of N bytes with FIFO never empty reaches S_DONE N+1 cycles after leaving S_IDLE.

Reset
REQ-024 On srst, SHALL clear: state to S_IDLE, rx_en, frame_valid, overflow, frame_len, drop_cnt, counter, every RAM word, iomem_ready, iomem_rdata.
REQ-025 o_fifo_rden SHALL be 0 during srst.
REQ-026 srst mid-frame SHALL abandon the frame; the remaining FIFO bytes are captured as a new frame once rx_en is re-enabled.

Configuration
REQ-027 Macro CTRL_RX_FILTER_EN defined: after pop of byte 5, if bytes 0-5 are neither FF:FF:FF:FF:FF:FF nor 01:80:C2:00:00:0X, SHALL go to S_DROP and increment drop_cnt (saturating at 255).
REQ-028 Frames of at most 6 bytes SHALL be accepted under the filter.
REQ-029 Macro undefined: no filter logic, S_DROP unreachable, drop_cnt reads 0.

Verification
REQ-030 Enable (write 0x80000000 to 0x16000000), push 64-byte frame 0x00..0x3F -> config reads 0xC0000040 (rx_en, frame_valid, frame_len=64); RAM word 0 = 0x03020100, word 15 = 0x3F3E3D3C.
REQ-031 Push 100-byte frame -> frame_len=100, overflow=1, word 15 holds bytes 60-63, exactly 100 pops.
REQ-032 While in S_DONE, push second frame -> zero pops; write 0x90000000 -> second frame captured.
REQ-033 Insert empty cycles mid-frame -> o_fifo_rden low while empty, frame data intact.
REQ-034 With CTRL_RX_FILTER_EN defined: unicast dest 00:11:22:33:44:55 -> dropped, drop_cnt=1, frame_valid=0; then dest 01:80:C2:00:00:00 -> captured.
REQ-035 Assert srst after 10 bytes -> all outputs and registers at reset values next cycle, RAM all zero.
